// File: rtl/operand_issue_ctrl_if.sv
// Operand issue bundle: operand stream, datapath x/en/out, result stream.
// Ports:
//   in_valid/in_ready/in_data     operand stream (producer -> ctrl)
//   x_out/en_out/result_in        datapath drive and result return
//   res_valid/res_ready/res_data  result stream (ctrl -> consumer)
//   busy                          ctrl has work buffered or in flight
// slave = the controller, master = its environment.
interface operand_issue_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] x_out;
  logic             en_out;
  logic [WIDTH-1:0] result_in;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             busy;

  modport master (
    output in_valid, in_data,
    output result_in, res_ready,
    input  in_ready, x_out, en_out,
    input  res_valid, res_data, busy
  );

  modport slave (
    input  in_valid, in_data,
    input  result_in, res_ready,
    output in_ready, x_out, en_out,
    output res_valid, res_data, busy
  );
endinterface

// File: rtl/operand_issue_ctrl.sv
// Operand FIFO + issue FSM for fixed-latency x/en/out datapaths.
// Ports: clk, rst (async, active high), bus (slave modport):
//   operand stream in, x/en to datapath, result_in back,
//   captured result stream out, busy.
// Macro ISSUE_BACK_TO_BACK_EN: HOLD may go straight to ISSUE.
module operand_issue_ctrl #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input logic                 clk,
  input logic                 rst,
  operand_issue_ctrl_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [LW-1:0]    r_wait;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_res;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_last;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = bus.in_valid && !w_full;
  // ISSUE never loops on itself, so entering it is the pop.
  assign w_pop   = (w_next == ISSUE);
  assign w_last  = (r_wait == LW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (!w_empty) w_next = ISSUE;
      ISSUE: w_next = WAIT;
      WAIT:  if (w_last) w_next = HOLD;
      HOLD: begin
        if (bus.res_ready) begin
`ifdef ISSUE_BACK_TO_BACK_EN
          w_next = w_empty ? IDLE : ISSUE;
`else
          w_next = IDLE;
`endif
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.en_out    = 1'b0;
    bus.res_valid = 1'b0;
    unique case (r_state)
      ISSUE:   bus.en_out    = 1'b1;
      HOLD:    bus.res_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.in_ready = !w_full;
  assign bus.busy     = (r_state != IDLE) || !w_empty;
  assign bus.x_out    = r_x;
  assign bus.res_data = r_res;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait <= '0;
      r_x    <= '0;
      r_res  <= '0;
    end else begin
      if (w_pop) r_x <= r_mem[r_rd_ptr];
      if (r_state == ISSUE) begin
        r_wait <= LW'(LATENCY);
      end else if (r_state == WAIT) begin
        r_wait <= r_wait - LW'(1);
      end
      // result_in is only meaningful in the last WAIT cycle
      if (r_state == WAIT && w_last) r_res <= bus.result_in;
    end
  end
endmodule

// File: tb/tb_operand_issue_ctrl.sv
// Bench for operand_issue_ctrl: vector table, directed corners,
// random traffic checked against a queue-based reference model.
module tb_operand_issue_ctrl;
  localparam int W = 32;
  localparam int D = 4;
  localparam int L = 2;
`ifdef ISSUE_BACK_TO_BACK_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  operand_issue_ctrl_if #(.WIDTH(W)) bus ();
  operand_issue_ctrl_if #(.WIDTH(W)) busb ();

  operand_issue_ctrl #(
    .WIDTH(W), .DEPTH(D), .LATENCY(L)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  operand_issue_ctrl #(
    .WIDTH(W), .DEPTH(D), .LATENCY(1)
  ) dut1 (
    .clk(clk), .rst(rst), .bus(busb)
  );

  // datapaths: 3x with 2-cycle latency, pass-through with 1
  logic [W-1:0] junk = '0;
  logic         a_v0 = 1'b0;
  logic         a_v1 = 1'b0;
  logic         b_v0 = 1'b0;
  logic [W-1:0] a_d0 = '0;
  logic [W-1:0] a_d1 = '0;
  logic [W-1:0] b_d0 = '0;

  always @(posedge clk) begin
    junk <= $urandom;
    a_v0 <= bus.en_out;
    a_d0 <= bus.x_out * 32'd3;
    a_v1 <= a_v0;
    a_d1 <= a_d0;
    b_v0 <= busb.en_out;
    b_d0 <= busb.x_out;
  end

  assign bus.result_in  = a_v1 ? a_d1 : junk;
  assign busb.result_in = b_v0 ? b_d0 : ~junk;

  int total  = 0;
  int passed = 0;

  task automatic chk(input string nm,
                     input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic chk1(input string nm,
                      input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0b expected %0b", nm, act, exp);
  endtask

  // ---------------- reference model ----------------
  bit           mon_en   = 1'b0;
  int           cyc      = 0;
  logic [W-1:0] pend[$];
  logic [W-1:0] resq[$];
  bit           inflight = 1'b0;
  bit           prev_en  = 1'b0;
  bit           prev_rv  = 1'b0;
  bit           prev_rr  = 1'b0;
  bit           gap_exp  = 1'b0;
  logic [W-1:0] prev_rd  = '0;
  logic [W-1:0] last_x   = '0;
  int           iss_cyc  = 0;
  int           hs_cyc   = 0;

  task automatic model_clear();
    pend.delete();
    resq.delete();
    inflight = 1'b0;
    prev_en  = 1'b0;
    prev_rv  = 1'b0;
    prev_rr  = 1'b0;
    gap_exp  = 1'b0;
    last_x   = '0;
  endtask

  task automatic mon_step();
    int occ;
    cyc++;
    occ = pend.size() - (bus.en_out ? 1 : 0);
    chk1("in_ready", bus.in_ready, occ < D);
    chk1("busy", bus.busy,
         (occ > 0) || bus.en_out || inflight);
    if (bus.en_out) begin
      chk1("en_single", prev_en || inflight, 1'b0);
      if (gap_exp) chk("issue_gap", cyc - hs_cyc, GAP);
      gap_exp = 1'b0;
      chk1("issue_has_op", pend.size() != 0, 1'b1);
      if (pend.size() != 0) begin
        chk("x_out", bus.x_out, pend[0]);
        resq.push_back(pend[0] * 32'd3);
        last_x = pend[0];
        void'(pend.pop_front());
      end
      inflight = 1'b1;
      iss_cyc  = cyc;
    end else begin
      chk("x_hold", bus.x_out, last_x);
      if (gap_exp && (cyc - hs_cyc) >= GAP) begin
        chk("issue_gap", cyc - hs_cyc, GAP);
        gap_exp = 1'b0;
      end
    end
    if (bus.res_valid) begin
      if (!prev_rv) chk("res_lat", cyc - iss_cyc, L + 1);
      else if (!prev_rr) chk("res_hold", bus.res_data, prev_rd);
      chk1("res_has_op", resq.size() != 0, 1'b1);
      if (bus.res_ready && resq.size() != 0) begin
        chk("res_data", bus.res_data, resq.pop_front());
        inflight = 1'b0;
        if (occ > 0) begin
          gap_exp = 1'b1;
          hs_cyc  = cyc;
        end
      end
    end
    if (bus.in_valid && bus.in_ready) pend.push_back(bus.in_data);
    prev_en = bus.en_out;
    prev_rv = bus.res_valid;
    prev_rr = bus.res_ready;
    prev_rd = bus.res_data;
  endtask

  always @(posedge clk) if (mon_en) mon_step();

  // ---------------- helpers ----------------
  // caller sits at a negedge; returns at the negedge after acceptance
  task automatic push(input logic [W-1:0] v);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk1("push_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic run_single(input logic [W-1:0] op,
                            input logic [W-1:0] exp);
    int en_k, rv_k, en_n;
    logic [W-1:0] xa, rd;
    en_k = 0; rv_k = 0; en_n = 0; xa = '0; rd = '0;
    @(negedge clk);
    bus.res_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = op;
    @(posedge clk);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (bus.en_out) begin
        en_n++;
        if (en_k == 0) begin
          en_k = k;
          xa   = bus.x_out;
        end
      end
      if (bus.res_valid && rv_k == 0) begin
        rv_k = k;
        rd   = bus.res_data;
      end
    end
    chk("t_en_cycle", en_k, 2);
    chk("t_en_count", en_n, 1);
    chk("t_x", xa, op);
    chk("t_rv_cycle", rv_k, L + 3);
    chk("t_res", rd, exp);
    chk("t_x_after", bus.x_out, op);
  endtask

  task automatic run_b(input logic [W-1:0] op);
    int en_k, rv_k;
    logic [W-1:0] rd;
    en_k = 0; rv_k = 0; rd = '0;
    @(negedge clk);
    busb.in_valid = 1'b1;
    busb.in_data  = op;
    @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      busb.in_valid = 1'b0;
      if (busb.en_out && en_k == 0) en_k = k;
      if (busb.res_valid && rv_k == 0) begin
        rv_k = k;
        rd   = busb.res_data;
      end
    end
    chk("l1_en_cycle", en_k, 2);
    chk("l1_rv_cycle", rv_k, 4);
    chk("l1_res", rd, op);
  endtask

  // which: 0 = ISSUE, 1 = WAIT, 2 = HOLD
  task automatic reset_in(input int which);
    bit hit, seen;
    int n, stale;
    hit = 1'b0; seen = 1'b0; n = 0; stale = 0;
    @(negedge clk);
    bus.res_ready = 1'b0;
    push(32'h11);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h22;
    while (!hit && n < 20) begin
      if (which == 0) hit = bus.en_out;
      else if (which == 1) hit = seen;
      else hit = bus.res_valid;
      seen = seen | bus.en_out;
      if (!hit) begin
        @(negedge clk);
        n++;
      end
    end
    chk1("rst_reach", hit, 1'b1);
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk1("rst_en", bus.en_out, 1'b0);
    chk1("rst_rv", bus.res_valid, 1'b0);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_rdy", bus.in_ready, 1'b1);
    chk("rst_x", bus.x_out, '0);
    chk("rst_rd", bus.res_data, '0);
    @(negedge clk);
    rst = 1'b0;
    bus.res_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.en_out || bus.res_valid || bus.busy) stale++;
    end
    chk("rst_stale", stale, 0);
  endtask

  typedef struct {
    logic [W-1:0] op;
    logic [W-1:0] exp;
  } vec_t;

  vec_t         tbl [5];
  logic [W-1:0] got[$];
  logic [W-1:0] fexp [4];

  initial begin
    int n, bad, ek, en_n;
    logic [W-1:0] rd0;
    tbl[0] = '{32'd2,         32'd6};
    tbl[1] = '{32'd0,         32'd0};
    tbl[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[3] = '{32'h5555_5555, 32'hFFFF_FFFF};
    tbl[4] = '{32'h8000_0000, 32'h8000_0000};
    fexp[0] = 32'd6;
    fexp[1] = 32'd9;
    fexp[2] = 32'd12;
    fexp[3] = 32'd15;

    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.res_ready  = 1'b1;
    busb.in_valid  = 1'b0;
    busb.in_data   = '0;
    busb.res_ready = 1'b1;

    #1;
    chk1("reset_en", bus.en_out, 1'b0);
    chk("reset_x", bus.x_out, '0);
    chk1("reset_rv", bus.res_valid, 1'b0);
    chk("reset_rd", bus.res_data, '0);
    chk1("reset_rdy", bus.in_ready, 1'b1);
    chk1("reset_busy", bus.busy, 1'b0);
    @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 5; i++) run_single(tbl[i].op, tbl[i].exp);

    // fill the FIFO behind a stalled result, then release
    @(negedge clk);
    bus.res_ready = 1'b0;
    for (int v = 1; v <= 5; v++) push(W'(v));
    chk1("fill_full", bus.in_ready, 1'b0);
    n = 0;
    while (!bus.res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    rd0 = bus.res_data;
    chk1("fill_rv", bus.res_valid, 1'b1);
    chk("fill_r0", rd0, 32'd3);
    bad = 0; en_n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!bus.res_valid || bus.res_data !== rd0) bad++;
      if (bus.en_out) en_n++;
    end
    chk("bp_stable", bad, 0);
    chk("bp_no_en", en_n, 0);
    bus.res_ready = 1'b1;
    got.delete();
    ek = 0;
    for (int k = 1; k <= 80 && got.size() < 4; k++) begin
      @(negedge clk);
      if (bus.en_out && ek == 0) ek = k;
      if (bus.res_valid) got.push_back(bus.res_data);
    end
    chk("bp_gap", ek, GAP);
    chk("fill_cnt", got.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("fill_order", (i < got.size()) ? got[i] : '0, fexp[i]);
    end

    // asynchronous reset mid-operation
    @(negedge clk);
    mon_en = 1'b0;
    for (int s = 0; s < 3; s++) reset_in(s);
    model_clear();
    mon_en = 1'b1;

    run_b(32'hFFFF_FFFF);
    run_b(32'h1234_5678);

    // random traffic, light then heavy backpressure
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      bus.in_valid  = ($urandom_range(0, 2) != 0);
      bus.in_data   = $urandom;
      if (c < 350) bus.res_ready = ($urandom_range(0, 3) != 0);
      else         bus.res_ready = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.res_ready = 1'b1;
    n = 0;
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk1("drain_busy", bus.busy, 1'b0);
    chk("drain_q", pend.size() + resq.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
